// File: rtl/regfile_read_arbiter.sv
// Arbitrates the register file's single read port between CPU reads and a per-frame
// snapshot scanner that fills a display shadow buffer. Optional macro: SNAP_DOUBLE_BUFFER_EN.
module regfile_read_arbiter #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              frame_start,
  input  logic              cpu_rd_req,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  output logic              cpu_rd_gnt,
  output logic              cpu_rd_valid,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  input  logic [ADDR_W-1:0] disp_sel,
  output logic [DATA_W-1:0] disp_data,
  output logic              snap_busy,
  output logic              snap_done,
  output logic              snap_miss,
  output logic [1:0]        o_dbg_state
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX   = (ADDR_W + 1)'(NREG - 1);
  localparam logic [3:0]      STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Handshake: cpu_rd_req is held with its address until cpu_rd_gnt is seen high in
  // the same cycle; the datum follows on cpu_rd_valid exactly one cycle after the grant.

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W:0]     r_idx;
  logic [ADDR_W:0]     w_next_idx;
  logic [3:0]          r_starve;
  logic [3:0]          w_next_starve;
  logic                r_cpu_valid;
  logic                r_wr_pend;
  logic [ADDR_W-1:0]   r_wr_idx;
  logic                w_cpu_gnt;
  logic                w_scan_gnt;
  logic                w_snap_miss;

  always_comb begin
    w_next_state  = r_state;
    w_next_idx    = r_idx;
    w_next_starve = r_starve;
    w_cpu_gnt     = 1'b0;
    w_scan_gnt    = 1'b0;
    w_snap_miss   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cpu_gnt = cpu_rd_req;
        if (frame_start) begin
          w_next_state  = S_SCAN;
          w_next_idx    = '0;
          w_next_starve = '0;
        end
      end
      S_SCAN: begin
        w_snap_miss = frame_start;
        // The CPU keeps priority until the scanner has lost STARVE_MAX times in a row.
        if (cpu_rd_req && (r_starve < STARVE_LIM)) begin
          w_cpu_gnt     = 1'b1;
          w_next_starve = r_starve + 4'd1;
        end else begin
          w_scan_gnt    = 1'b1;
          w_next_idx    = r_idx + 1'b1;
          w_next_starve = '0;
          if (r_idx == LAST_IDX) begin
            w_next_state = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        w_cpu_gnt    = cpu_rd_req;
        w_snap_miss  = frame_start;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_starve    <= '0;
      r_cpu_valid <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_wr_idx    <= '0;
    end else begin
      r_state     <= w_next_state;
      r_idx       <= w_next_idx;
      r_starve    <= w_next_starve;
      r_cpu_valid <= w_cpu_gnt;
      r_wr_pend   <= w_scan_gnt;
      r_wr_idx    <= r_idx[ADDR_W-1:0];
    end
  end

  assign cpu_rd_gnt   = w_cpu_gnt;
  assign cpu_rd_valid = r_cpu_valid;
  assign cpu_rd_data  = r_cpu_valid ? rf_rd_data : '0;
  assign rf_rd_en     = w_cpu_gnt | w_scan_gnt;
  assign rf_rd_addr   = w_cpu_gnt  ? cpu_rd_addr :
                        w_scan_gnt ? r_idx[ADDR_W-1:0] : '0;
  assign snap_busy    = (r_state == S_SCAN) || (r_state == S_DRAIN);
  assign snap_done    = (r_state == S_DRAIN);
  assign snap_miss    = w_snap_miss;
  assign o_dbg_state  = r_state;

`ifdef SNAP_DOUBLE_BUFFER_EN
  // Scanner fills the back bank; banks swap at the edge ending the DRAIN cycle,
  // which is the same edge that lands the final datum.
  logic [DATA_W-1:0] r_bank [2][NREG];
  logic              r_front;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_front <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NREG; i++) begin
          r_bank[b][i] <= '0;
        end
      end
    end else begin
      if (r_wr_pend) begin
        r_bank[~r_front][r_wr_idx] <= rf_rd_data;
      end
      if (r_state == S_DRAIN) begin
        r_front <= ~r_front;
      end
    end
  end

  assign disp_data = r_bank[r_front][disp_sel];
`else
  logic [DATA_W-1:0] r_shadow [NREG];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (r_wr_pend) begin
      r_shadow[r_wr_idx] <= rf_rd_data;
    end
  end

  assign disp_data = r_shadow[disp_sel];
`endif

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scoreboard bench for regfile_read_arbiter: drivers push expected CPU data, scanner
// addresses and snap_done cycles; a negedge monitor pops and compares.
module tb_regfile_read_arbiter;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;
  localparam int NREG   = 8;

`ifdef SNAP_DOUBLE_BUFFER_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              frame_start = 1'b0;
  logic              cpu_rd_req = 1'b0;
  logic [ADDR_W-1:0] cpu_rd_addr = '0;
  logic              cpu_rd_gnt;
  logic              cpu_rd_valid;
  logic [DATA_W-1:0] cpu_rd_data;
  logic              rf_rd_en;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data = '0;
  logic [ADDR_W-1:0] disp_sel = '0;
  logic [DATA_W-1:0] disp_data;
  logic              snap_busy;
  logic              snap_done;
  logic              snap_miss;
  logic [1:0]        o_dbg_state;

  regfile_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST), .frame_start(frame_start),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_gnt(cpu_rd_gnt),
    .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .disp_sel(disp_sel), .disp_data(disp_data),
    .snap_busy(snap_busy), .snap_done(snap_done), .snap_miss(snap_miss),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset / register file model ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [DATA_W-1:0] rf_mem [NREG];
  always @(posedge CLK) begin
    if (rf_rd_en) rf_rd_data <= rf_mem[rf_rd_addr];
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] scan_q[$];
  int                done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (cpu_rd_valid) begin
        if (exp_q.size() == 0) check("cpu_valid_unexpected", 32'd1, 32'd0);
        else check("cpu_rd_data", 32'(cpu_rd_data), 32'(exp_q.pop_front()));
      end
      if (rf_rd_en && !cpu_rd_gnt) begin
        if (scan_q.size() == 0) check("scan_read_unexpected", 32'(rf_rd_addr), 32'hFFFF_FFFF);
        else check("scan_addr", 32'(rf_rd_addr), 32'(scan_q.pop_front()));
      end
      if (snap_done) begin
        if (done_q.size() == 0) check("snap_done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else check("snap_done_cycle", 32'(cyc), 32'(done_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_scan(input int n, input int t_done);
    for (int i = 0; i < n; i++) scan_q.push_back(ADDR_W'(i));
    if (t_done >= 0) done_q.push_back(t_done);
  endtask

  task automatic pulse_frame(output int t);
    frame_start = 1'b1;
    t = cyc;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (snap_busy && n < budget) begin
      tick();
      n++;
    end
    check("scan_finished", 32'(snap_busy), 32'd0);
  endtask

  task automatic check_quiet(input string name);
    check(name, {7'd0, cpu_rd_gnt, cpu_rd_valid, cpu_rd_data, rf_rd_en, rf_rd_addr,
                 snap_busy, snap_done, snap_miss}, 32'd0);
  endtask

  task automatic check_disp_all(input string name, input logic [DATA_W-1:0] base);
    for (int i = 0; i < NREG; i++) begin
      disp_sel = ADDR_W'(i);
      #1;
      check(name, 32'(disp_data), (base == 0) ? 32'd0 : 32'(base + DATA_W'(i)));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    logic [DATA_W-1:0] exp_d;
    for (int i = 0; i < NREG; i++) rf_mem[i] = 16'h1000 + DATA_W'(i);

    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    mon_en = 1'b1;
    #1;
    check_quiet("reset_outputs");
    check("reset_state", 32'(o_dbg_state), 32'd0);
    check_disp_all("reset_shadow", 16'h0);

    // CPU read in IDLE: same-cycle grant, data next cycle only
    tick();
    rf_mem[3] = 16'hBEEF;
    cpu_rd_req = 1'b1;
    cpu_rd_addr = 3'd3;
    #1;
    check("idle_cpu_gnt", 32'(cpu_rd_gnt), 32'd1);
    check("idle_cpu_addr", 32'(rf_rd_addr), 32'd3);
    exp_q.push_back(16'hBEEF);
    tick();
    cpu_rd_req = 1'b0;
    #1;
    check("idle_cpu_gnt_drop", 32'(cpu_rd_gnt), 32'd0);
    tick();
    tick();
    rf_mem[3] = 16'h1003;

    // Idle snapshot: reads 0..7 on T+1..T+8, snap_done at T+9
    push_scan(NREG, cyc + 9);
    pulse_frame(t);
    wait_idle(30);
    disp_sel = 3'd5;
    #1;
    check("idle_scan_disp5", 32'(disp_data), 32'h1005);
    check_disp_all("idle_scan_disp", 16'h1000);

    // Continuous CPU requests: 4 CPU grants then one scanner slot, done at T+41
    tick();
    push_scan(NREG, cyc + 41);
    pulse_frame(t);
    cpu_rd_req = 1'b1;
    cpu_rd_addr = 3'd6;
    for (int k = 0; k < 40; k++) begin
      #1;
      check("starve_gnt", 32'(cpu_rd_gnt), (k % 5 != 4) ? 32'd1 : 32'd0);
      if (k % 5 != 4) exp_q.push_back(16'h1006);
      tick();
    end
    cpu_rd_req = 1'b0;
    wait_idle(10);

    // frame_start mid-scan and on the DRAIN cycle: misses, timing unchanged
    tick();
    push_scan(NREG, cyc + 9);
    pulse_frame(t);
    tick();
    tick();
    frame_start = 1'b1;
    #1;
    check("miss_mid_scan", 32'(snap_miss), 32'd1);
    tick();
    frame_start = 1'b0;
    #1;
    check("miss_one_cycle", 32'(snap_miss), 32'd0);
    while (cyc < t + 9) tick();
    frame_start = 1'b1;
    #1;
    check("miss_in_drain", 32'(snap_miss), 32'd1);
    check("drain_done", 32'(snap_done), 32'd1);
    tick();
    frame_start = 1'b0;
    #1;
    check("drain_frame_not_queued", 32'(snap_busy), 32'd0);

    // Reset mid-scan after three registers are captured
    tick();
    push_scan(5, -1);
    pulse_frame(t);
    while (cyc < t + 5) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    check_quiet("midscan_reset_outputs");
    check_disp_all("midscan_reset_shadow", 16'h0);
    repeat (12) tick();

    // Full scan after the abort
    push_scan(NREG, cyc + 9);
    pulse_frame(t);
    wait_idle(30);
    check_disp_all("post_reset_scan_disp", 16'h1000);

    // Second snapshot with new values: watch entry 2 update
    tick();
    for (int i = 0; i < NREG; i++) rf_mem[i] = 16'h2000 + DATA_W'(i);
    disp_sel = 3'd2;
    push_scan(NREG, cyc + 9);
    frame_start = 1'b1;
    t = cyc;
    for (int c = 0; c < 12; c++) begin
      #1;
      exp_d = (c >= (DBUF ? 10 : 5)) ? 16'h2002 : 16'h1002;
      check("update_disp2", 32'(disp_data), 32'(exp_d));
      tick();
      frame_start = 1'b0;
    end
    wait_idle(10);
    check_disp_all("second_scan_disp", 16'h2000);

    repeat (4) tick();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("scan_q_empty", 32'(scan_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
